// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
// - seq_state_t : FSM state encoding (HOLD / RELEASE / DONE)
// - cnt_width() : width of the hold/gap cycle counter, large enough to hold
//                 max(hold_cycles, stage_gap) without wrapping.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_t;

  function automatic int cnt_width(input int hold_cycles, input int stage_gap);
    int m;
    m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Clear/enable up-counter with terminal-count compare.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset (count -> 0)
//   clr_i    - synchronous clear, takes priority over enable
//   en_i     - count enable
//   tc_val_i - terminal value compared against the current count
//   tc_o     - high while the count equals tc_val_i
module rst_seq_cnt
  import rst_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release sequencer.
// After rst_i drops, all stages are held in reset for HOLD_CYCLES edges, then
// stage 0 is released and each following stage STAGE_GAP edges later. Once all
// stages are out of reset, a level soft request re-runs the whole sequence.
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - synchronous active-high reset from upstream synchronizer
//   soft_rst_req_i - level request to re-run the sequence (honoured in DONE)
//   soft_rst_ack_o - one-cycle pulse when a soft request is accepted
//   stage_rst_n_o  - active-low per-stage resets, bit 0 released first
//   seq_done_o     - all stages released
//   seq_busy_o     - inverse of seq_done_o
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_rst_req_i,
  output logic                  soft_rst_ack_o,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  seq_done_o,
  output logic                  seq_busy_o
);

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("reset_sequencer: NUM_STAGES must be in 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_stage_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // The counter starts at 0 on the edge that enters a phase, so the edge that
  // completes a phase of N cycles sees a count of N-1.
  localparam logic [CNT_W-1:0]      HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_TC   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STG_ONE  = NUM_STAGES'(1);

  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  ack_q, ack_d;

  logic                  cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]      tc_val;
  logic                  release_now, accept, last_stage;

  assign tc_val      = (state_q == HOLD) ? HOLD_TC : GAP_TC;
  assign release_now = cnt_tc && ((state_q == HOLD) || (state_q == RELEASE));
  assign accept      = (state_q == DONE) && soft_rst_req_i;
  // idx_q is the stage released next; in HOLD it is 0, which is also the last
  // stage when NUM_STAGES == 1, so HOLD goes straight to DONE in that case.
  assign last_stage  = (idx_q == LAST_IDX);

  rst_seq_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (tc_val),
    .tc_o     (cnt_tc)
  );

  // State register; outputs are registered here too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= ~done_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state, stage index and counter control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      HOLD, RELEASE: begin
        cnt_en = 1'b1;
        if (release_now) begin
          cnt_clr = 1'b1;
          if (last_stage) begin
            state_d = DONE;
          end else begin
            state_d = RELEASE;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (accept) begin
          cnt_clr = 1'b1;
          idx_d   = '0;
          state_d = HOLD;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        idx_d   = '0;
        state_d = HOLD;
      end
    endcase
  end

  // Next values of the registered outputs. Stages release in order, so the
  // released set is always a run of ones from bit 0 and can grow by shifting.
  always_comb begin
    stage_d = stage_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    if (release_now) begin
      stage_d = (stage_q << 1) | STG_ONE;
      done_d  = last_stage;
    end
    if (accept) begin
      stage_d = '0;
      done_d  = 1'b0;
      ack_d   = 1'b1;
    end
  end

  assign stage_rst_n_o  = stage_q;
  assign seq_done_o     = done_q;
  assign seq_busy_o     = busy_q;
  assign soft_rst_ack_o = ack_q;

endmodule
